// File: rtl/seg7_scan_lookup.sv
// Multiplexed seven-segment scanner with BCD glyph lookup,
// frame-synchronous shadow loading, leading-zero blanking and dead time.
module seg7_scan_lookup #(
    parameter int NUM_DIGITS  = 6,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    input  logic                          lz_en,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = 4 * NUM_DIGITS;

    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_BLK = DW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_INV  =
        (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be in 2..8");
    end
    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("BLANK_CYC must be less than SCAN_DIV");
    end

    logic [DW-1:0]         r_div;
    logic [IW-1:0]         r_idx;
    logic                  r_started;
    logic [BW-1:0]         r_pend_bcd;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_pend_valid;
    logic [BW-1:0]         r_act_bcd;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_div_wrap;
    logic                  w_frame_wrap;
    logic                  w_dead;
    logic [3:0]            w_nib;
    logic                  w_dp_bit;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;
    logic [NUM_DIGITS-1:0] w_an_raw;
    logic [6:0]            w_glyph;

    function automatic logic [6:0] f_glyph(input logic [3:0] i_d);
        logic [6:0] v;
        case (i_d)
            4'h0:    v = 7'h3F;
            4'h1:    v = 7'h06;
            4'h2:    v = 7'h5B;
            4'h3:    v = 7'h4F;
            4'h4:    v = 7'h66;
            4'h5:    v = 7'h6D;
            4'h6:    v = 7'h7D;
            4'h7:    v = 7'h07;
            4'h8:    v = 7'h7F;
            4'h9:    v = 7'h6F;
            4'hF:    v = 7'h40;
            default: v = 7'h00;
        endcase
        return v;
    endfunction

    assign w_div_wrap   = (r_div == DIV_MAX);
    assign w_frame_wrap = w_div_wrap && (r_idx == IDX_MAX);
    assign w_dead       = (r_div < DIV_BLK);

    always_comb begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
        w_an_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == r_idx) begin
                w_nib       = r_act_bcd[i*4 +: 4];
                w_dp_bit    = r_act_dp[i];
                w_an_raw[i] = !w_dead;
            end
        end
    end

    // Walk from the most significant digit down while digits stay zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_act_bcd[k*4 +: 4] == 4'h0);
            w_blank[k] = lz_en && w_zero_run && (k != 0);
        end
    end

    always_comb begin
        w_glyph = f_glyph(w_nib);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == r_idx && w_blank[i]) begin
                w_glyph = 7'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + DW'(1);
            if (w_div_wrap) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end
            if (w_frame_wrap) begin
                r_started <= 1'b1;
            end
        end
    end

    // Active data only changes at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_act_bcd    <= '0;
            r_act_dp     <= '0;
        end else begin
            if (w_frame_wrap && r_pend_valid) begin
                r_act_bcd <= r_pend_bcd;
                r_act_dp  <= r_pend_dp;
            end
            if (load) begin
                r_pend_bcd   <= bcd_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end else if (w_frame_wrap) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_INV;
            r_dp  <= DP_INV;
            r_an  <= AN_INV;
        end else begin
            r_seg <= w_glyph ^ SEG_INV;
            r_dp  <= w_dp_bit ^ DP_INV;
            r_an  <= w_an_raw ^ AN_INV;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign digit_idx   = r_idx;
    assign frame_start = r_started && (r_div == '0) && (r_idx == '0);

endmodule

// File: tb/tb_seg7_scan_lookup.sv
// Scoreboard bench for seg7_scan_lookup: a cycle-level display model
// predicts every registered output; a monitor compares on the falling edge.
module tb_seg7_scan_lookup;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * SD;

    logic          clk;
    logic          rst_n;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          load;
    logic          lz_en;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic [1:0]    digit_idx;
    logic          frame_start;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int   t;
    int   act[ND];
    int   pend[ND];
    int   act_dp;
    int   pend_dp;
    bit   pv;

    seg7_scan_lookup #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC),
        .SEG_ACT_LOW(1),
        .AN_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            15: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0d got %0h want %0h", name, t, got, want);
        end
    endtask

    // Reference model: the display state is t cycles since reset release.
    always @(posedge clk) begin
        int   dv, ix, hi;
        bit   bl;
        logic [6:0] g;
        exp_t e;
        if (!rst_n) begin
            t = 0;
            pv = 0;
            act_dp = 0;
            pend_dp = 0;
            for (int k = 0; k < ND; k++) begin
                act[k] = 0;
                pend[k] = 0;
            end
        end else begin
            dv = t % SD;
            ix = (t / SD) % ND;
            hi = -1;
            for (int k = 0; k < ND; k++) if (act[k] != 0) hi = k;
            bl = lz_en && ix >= 1 && ix > hi;
            g = bl ? 7'h00 : glyph(act[ix]);
            e.seg = ~g;
            e.dp = ~act_dp[ix];
            e.an = (dv < BC) ? 4'hF : ~(4'b0001 << ix);
            if (t % FRAME == FRAME - 1 && pv) begin
                act = pend;
                act_dp = pend_dp;
                pv = 0;
            end
            if (load) begin
                for (int k = 0; k < ND; k++) pend[k] = int'(bcd_in[k*4 +: 4]);
                pend_dp = int'(dp_in);
                pv = 1;
            end
            t++;
            e.idx = 2'((t / SD) % ND);
            e.fs = (t % FRAME == 0);
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg", int'(seg), int'(e.seg));
            chk("dp", int'(dp), int'(e.dp));
            chk("an", int'(an), int'(e.an));
            chk("digit_idx", int'(digit_idx), int'(e.idx));
            chk("frame_start", int'(frame_start), int'(e.fs));
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        @(negedge clk);
        #1;
        while (t % FRAME != p && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_phase got %0d want %0d", t % FRAME, p);
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        bcd_in = b;
        dp_in = d;
        load = 1'b1;
        @(negedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, int'(an), 'hF);
        chk({tag, "_seg"}, int'(seg), 'h7F);
        chk({tag, "_dp"}, int'(dp), 1);
        chk({tag, "_idx"}, int'(digit_idx), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            v[k*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        bcd_in = '0;
        dp_in = '0;
        load = 1'b0;
        lz_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        wait_phase(13);
        do_load(16'h1234, 4'b0100);
        repeat (2 * FRAME) @(negedge clk);

        lz_en = 1'b1;
        wait_phase(3);
        do_load(16'h0050, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);
        #1;
        lz_en = 1'b0;
        repeat (FRAME) @(negedge clk);

        wait_phase(20);
        do_load(16'hFA09, 4'b1001);
        repeat (2 * FRAME) @(negedge clk);

        wait_phase(5);
        do_load(16'h1111, 4'b0001);
        wait_phase(10);
        do_load(16'h2222, 4'b0010);
        wait_phase(FRAME - 1);
        do_load(16'h3333, 4'b0100);
        repeat (3 * FRAME) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            lz_en = 1'($urandom_range(0, 1));
            wait_phase($urandom_range(0, FRAME - 1));
            do_load(rand_bcd(), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (FRAME) @(negedge clk);

        lz_en = 1'b0;
        wait_phase(2);
        do_load(16'h8765, 4'b1111);
        wait_phase(2 * SD + 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * FRAME) @(negedge clk);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
